// File: rtl/ctrl_pipe_dec_pkg.sv
// Shared types for the RV32I control decoder and its E/M/W control pipeline.
package ctrl_pipe_dec_pkg;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } alu_control_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // E-stage control word; the immediate select is consumed in D only
    typedef struct packed {
        logic         valid;
        logic         reg_write;
        logic         mem_write;
        logic         branch;
        logic         jump;
        logic         jalr;
        logic         alu_src_a;
        logic         alu_src_b;
        result_src_t  result_src;
        alu_control_t alu_control;
        logic [2:0]   branch_type;
    } ctrl_word_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        result_src_t result_src;
    } mem_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        result_src_t result_src;
    } wb_ctrl_t;

    function automatic ctrl_word_t ctrl_bubble();
        ctrl_word_t w;
        w             = '0;
        w.result_src  = RES_ALU;
        w.alu_control = ALU_ADD;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_pipe_dec_rv32i_ctrl_dec.sv
// Combinational RV32I main decoder: opcode/funct3 to control word, immediate select and illegal flag.
module rv32i_ctrl_dec
    import ctrl_pipe_dec_pkg::*;
#(
    parameter bit BRANCH_EXT     = 1'b1,
    parameter bit ILLEGAL_DETECT = 1'b1
) (
    input  logic       i_valid,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    output ctrl_word_t o_ctrl,
    output imm_src_t   o_imm_src,
    output logic       o_illegal
);

    ctrl_word_t w_dec;
    imm_src_t   w_imm;
    logic       w_legal;

    always_comb begin
        w_dec   = ctrl_bubble();
        w_imm   = IMM_I;
        w_legal = 1'b1;
        case (i_op)
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src_b  = 1'b1;
                w_dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                w_dec.mem_write = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_imm           = IMM_S;
            end
            OP_R: begin
                w_dec.reg_write   = 1'b1;
                w_dec.alu_control = ALU_RTYPE;
            end
            OP_I: begin
                w_dec.reg_write   = 1'b1;
                w_dec.alu_src_b   = 1'b1;
                w_dec.alu_control = ALU_ITYPE;
            end
            OP_BRANCH: begin
                // funct3 010/011 are unassigned branch encodings
                if (i_funct3 == 3'b010 || i_funct3 == 3'b011 ||
                    (!BRANCH_EXT && i_funct3 != 3'b000)) begin
                    w_legal = 1'b0;
                end else begin
                    w_dec.branch      = 1'b1;
                    w_dec.alu_control = ALU_SUB;
                    w_dec.branch_type = i_funct3;
                    w_imm             = IMM_B;
                end
            end
            OP_JAL: begin
                w_dec.reg_write  = 1'b1;
                w_dec.jump       = 1'b1;
                w_dec.result_src = RES_PC4;
                w_imm            = IMM_J;
            end
            OP_JALR: begin
                if (i_funct3 != 3'b000) begin
                    w_legal = 1'b0;
                end else begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.jump       = 1'b1;
                    w_dec.jalr       = 1'b1;
                    w_dec.alu_src_b  = 1'b1;
                    w_dec.result_src = RES_PC4;
                end
            end
            OP_LUI: begin
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src_b  = 1'b1;
                w_dec.result_src = RES_IMM;
                w_imm            = IMM_U;
            end
            OP_AUIPC: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src_a = 1'b1;
                w_dec.alu_src_b = 1'b1;
                w_imm           = IMM_U;
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_ctrl    = ctrl_bubble();
        o_imm_src = IMM_I;
        if (i_valid && w_legal) begin
            o_ctrl       = w_dec;
            o_ctrl.valid = 1'b1;
            o_imm_src    = w_imm;
        end
    end

    assign o_illegal = ILLEGAL_DETECT ? (i_valid & ~w_legal) : 1'b0;

endmodule

// File: rtl/ctrl_pipe_dec.sv
// RV32I control decode in D, carried through E/M/W registers with stall/flush, plus saturating illegal-op counter.
module ctrl_pipe_dec
    import ctrl_pipe_dec_pkg::*;
#(
    parameter bit          BRANCH_EXT     = 1'b1,
    parameter bit          ILLEGAL_DETECT = 1'b1,
    parameter int unsigned ILL_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_d,
    input  logic [6:0]           op_d,
    input  logic [2:0]           funct3_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic                 flush_m,
    output logic [2:0]           imm_src_d,
    output logic                 illegal_d,
    output logic                 reg_write_e,
    output logic                 mem_write_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic                 alu_src_a_e,
    output logic                 alu_src_b_e,
    output logic [1:0]           result_src_e,
    output alu_control_t         alu_control_e,
    output logic [2:0]           branch_type_e,
    output logic                 valid_e,
    output logic                 valid_m,
    output logic                 valid_w,
    output logic                 reg_write_m,
    output logic                 mem_write_m,
    output logic [1:0]           result_src_m,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic [ILL_CNT_W-1:0] illegal_cnt,
    output logic                 illegal_seen
);

    ctrl_word_t           w_ctrl_d;
    imm_src_t             w_imm_src;
    logic                 w_illegal;
    logic                 w_cnt_inc;
    ctrl_word_t           r_ctrl_e;
    mem_ctrl_t            r_ctrl_m;
    wb_ctrl_t             r_ctrl_w;
    logic [ILL_CNT_W-1:0] r_cnt;
    logic                 r_seen;

    rv32i_ctrl_dec #(
        .BRANCH_EXT     (BRANCH_EXT),
        .ILLEGAL_DETECT (ILLEGAL_DETECT)
    ) u_dec (
        .i_valid   (valid_d),
        .i_op      (op_d),
        .i_funct3  (funct3_d),
        .o_ctrl    (w_ctrl_d),
        .o_imm_src (w_imm_src),
        .o_illegal (w_illegal)
    );

    assign imm_src_d = w_imm_src;
    assign illegal_d = w_illegal;
    // Only words actually accepted into E are counted
    assign w_cnt_inc = w_illegal & ~stall_e & ~flush_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_e <= ctrl_bubble();
        end else if (flush_e) begin
            r_ctrl_e <= ctrl_bubble();
        end else if (!stall_e) begin
            r_ctrl_e <= w_ctrl_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_m <= '0;
        end else if (flush_m) begin
            r_ctrl_m <= '0;
        end else begin
            r_ctrl_m.valid      <= r_ctrl_e.valid;
            r_ctrl_m.reg_write  <= r_ctrl_e.reg_write;
            r_ctrl_m.mem_write  <= r_ctrl_e.mem_write;
            r_ctrl_m.result_src <= r_ctrl_e.result_src;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_w <= '0;
        end else begin
            r_ctrl_w.valid      <= r_ctrl_m.valid;
            r_ctrl_w.reg_write  <= r_ctrl_m.reg_write;
            r_ctrl_w.result_src <= r_ctrl_m.result_src;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_seen <= 1'b0;
        end else if (w_cnt_inc) begin
            r_seen <= 1'b1;
            if (r_cnt != {ILL_CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign valid_e       = r_ctrl_e.valid;
    assign reg_write_e   = r_ctrl_e.reg_write;
    assign mem_write_e   = r_ctrl_e.mem_write;
    assign branch_e      = r_ctrl_e.branch;
    assign jump_e        = r_ctrl_e.jump;
    assign jalr_e        = r_ctrl_e.jalr;
    assign alu_src_a_e   = r_ctrl_e.alu_src_a;
    assign alu_src_b_e   = r_ctrl_e.alu_src_b;
    assign result_src_e  = r_ctrl_e.result_src;
    assign alu_control_e = r_ctrl_e.alu_control;
    assign branch_type_e = r_ctrl_e.branch_type;

    assign valid_m       = r_ctrl_m.valid;
    assign reg_write_m   = r_ctrl_m.reg_write;
    assign mem_write_m   = r_ctrl_m.mem_write;
    assign result_src_m  = r_ctrl_m.result_src;

    assign valid_w       = r_ctrl_w.valid;
    assign reg_write_w   = r_ctrl_w.reg_write;
    assign result_src_w  = r_ctrl_w.result_src;

    assign illegal_cnt   = r_cnt;
    assign illegal_seen  = r_seen;

endmodule

// File: tb/tb_ctrl_pipe_dec.sv
// Bench for ctrl_pipe_dec: table-driven expected decode, W-stage scoreboard queue, BRANCH_EXT=0 second instance.
module tb_ctrl_pipe_dec;
    import ctrl_pipe_dec_pkg::*;

    logic clk;
    logic reset, valid_d, stall_e, flush_e, flush_m;
    logic [6:0] op_d;
    logic [2:0] funct3_d;

    logic [2:0] imm_src_d, branch_type_e;
    logic illegal_d, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_a_e, alu_src_b_e;
    logic [1:0] result_src_e, result_src_m, result_src_w;
    alu_control_t alu_control_e;
    logic valid_e, valid_m, valid_w, reg_write_m, mem_write_m, reg_write_w, illegal_seen;
    logic [7:0] illegal_cnt;

    logic [2:0] imm_src_d_b, branch_type_e_b;
    logic illegal_d_b, reg_write_e_b, mem_write_e_b, branch_e_b, jump_e_b, jalr_e_b, alu_src_a_e_b, alu_src_b_e_b;
    logic [1:0] result_src_e_b, result_src_m_b, result_src_w_b;
    alu_control_t alu_control_e_b;
    logic valid_e_b, valid_m_b, valid_w_b, reg_write_m_b, mem_write_m_b, reg_write_w_b, illegal_seen_b;
    logic [7:0] illegal_cnt_b;

    ctrl_pipe_dec #(.BRANCH_EXT(1'b1), .ILLEGAL_DETECT(1'b1), .ILL_CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d), .funct3_d(funct3_d),
        .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
        .result_src_e(result_src_e), .alu_control_e(alu_control_e), .branch_type_e(branch_type_e),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w),
        .illegal_cnt(illegal_cnt), .illegal_seen(illegal_seen)
    );

    ctrl_pipe_dec #(.BRANCH_EXT(1'b0), .ILLEGAL_DETECT(1'b1), .ILL_CNT_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .valid_d(valid_d), .op_d(op_d), .funct3_d(funct3_d),
        .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
        .imm_src_d(imm_src_d_b), .illegal_d(illegal_d_b),
        .reg_write_e(reg_write_e_b), .mem_write_e(mem_write_e_b), .branch_e(branch_e_b),
        .jump_e(jump_e_b), .jalr_e(jalr_e_b), .alu_src_a_e(alu_src_a_e_b), .alu_src_b_e(alu_src_b_e_b),
        .result_src_e(result_src_e_b), .alu_control_e(alu_control_e_b), .branch_type_e(branch_type_e_b),
        .valid_e(valid_e_b), .valid_m(valid_m_b), .valid_w(valid_w_b),
        .reg_write_m(reg_write_m_b), .mem_write_m(mem_write_m_b), .result_src_m(result_src_m_b),
        .reg_write_w(reg_write_w_b), .result_src_w(result_src_w_b),
        .illegal_cnt(illegal_cnt_b), .illegal_seen(illegal_seen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, rw, mw, br, jp, jr, sa, sb, rs[1:0], alu[1:0], btype[2:0]}
    logic [14:0] e_vec;
    logic [4:0]  m_vec;
    assign e_vec = {valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
                    alu_src_a_e, alu_src_b_e, result_src_e, alu_control_e, branch_type_e};
    assign m_vec = {valid_m, reg_write_m, mem_write_m, result_src_m};

    typedef struct packed {
        logic        legal;
        logic [2:0]  imm;
        logic [14:0] e;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] exp_e;
    logic [4:0]  exp_m;
    logic [7:0]  exp_cnt;
    logic [2:0]  sb_q[$];
    logic        en_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t exp_dec(input logic [6:0] op, input logic [2:0] f3, input logic bext);
        exp_t r;
        r.legal = 1'b1;
        r.imm   = 3'b000;
        r.e     = '0;
        case (op)
            7'b0000011: r.e = {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, ALU_ADD, 3'b000};
            7'b0100011: begin r.e = {1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 2'b00, ALU_ADD, 3'b000}; r.imm = 3'b001; end
            7'b0110011: r.e = {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, ALU_RTYPE, 3'b000};
            7'b0010011: r.e = {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, ALU_ITYPE, 3'b000};
            7'b1100011: begin
                r.legal = (f3 != 3'b010) && (f3 != 3'b011) && (bext || f3 == 3'b000);
                r.e = {1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 2'b00, ALU_SUB, f3};
                r.imm = 3'b010;
            end
            7'b1101111: begin r.e = {1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 2'b10, ALU_ADD, 3'b000}; r.imm = 3'b011; end
            7'b1100111: begin
                r.legal = (f3 == 3'b000);
                r.e = {1'b1, 1'b1, 1'b0, 3'b011, 1'b0, 1'b1, 2'b10, ALU_ADD, 3'b000};
            end
            7'b0110111: begin r.e = {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'b11, ALU_ADD, 3'b000}; r.imm = 3'b100; end
            7'b0010111: begin r.e = {1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 2'b00, ALU_ADD, 3'b000}; r.imm = 3'b100; end
            default: r.legal = 1'b0;
        endcase
        if (!r.legal) begin
            r.e   = '0;
            r.imm = 3'b000;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (valid_w) begin
            if (sb_q.size() == 0) chk("w_unexpected", valid_w, 1'b0);
            else chk("w_word", {reg_write_w, result_src_w}, sb_q.pop_front());
        end else begin
            chk("w_bubble", {reg_write_w, result_src_w}, 3'b000);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic st, input logic fe, input logic fm);
        exp_t x;
        logic acc;
        valid_d  = v;
        op_d     = op;
        funct3_d = f3;
        stall_e  = st;
        flush_e  = fe;
        flush_m  = fm;
        x = exp_dec(op, f3, 1'b1);
        #1;
        chk("imm_src_d", imm_src_d, (v && x.legal) ? x.imm : 3'b000);
        chk("illegal_d", illegal_d, v && !x.legal);
        acc   = !st && !fe;
        exp_m = fm ? 5'b0 : {exp_e[14:12], exp_e[6:5]};
        if (fe) exp_e = '0;
        else if (!st) exp_e = (v && x.legal) ? x.e : 15'b0;
        if (acc && v && x.legal) sb_q.push_back({x.e[13], x.e[6:5]});
        if (acc && v && !x.legal && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        tick();
        chk("e_stage", e_vec, exp_e);
        chk("m_stage", m_vec, exp_m);
        chk("ill_cnt", illegal_cnt, exp_cnt);
        chk("ill_seen", illegal_seen, exp_cnt != 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 7'h00, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; valid_d = 1'b0; op_d = '0; funct3_d = '0;
        stall_e = 1'b0; flush_e = 1'b0; flush_m = 1'b0;
        exp_e = '0; exp_m = '0; exp_cnt = '0; en_acc = 1'b0;
        #2;
        chk("rst_e", e_vec, 15'b0);
        chk("rst_m", m_vec, 5'b0);
        chk("rst_w", {valid_w, reg_write_w, result_src_w}, 4'b0);
        chk("rst_cnt", {illegal_seen, illegal_cnt}, 9'b0);
        #10 reset = 1'b0;

        // lui through all three stages
        drive(1'b1, 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("lui_rw_e", reg_write_e, 1'b1);
        chk("lui_rs_e", result_src_e, 2'b11);
        idle(2);
        chk("lui_rw_w", reg_write_w, 1'b1);
        chk("lui_rs_w", result_src_w, 2'b11);
        idle(1);

        // auipc then jalr back-to-back
        drive(1'b1, 7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("auipc_sa_e", alu_src_a_e, 1'b1);
        chk("auipc_rs_e", result_src_e, 2'b00);
        drive(1'b1, 7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("jalr_j_e", {jump_e, jalr_e, result_src_e}, 4'b1110);
        idle(3);

        // load-use: load held in E two cycles, M bubbled, dependent R-type follows
        drive(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        chk("stall_hold_e", result_src_e, 2'b01);
        chk("stall_m_bub", {valid_m, reg_write_m}, 2'b00);
        drive(1'b1, 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        chk("stall_m_bub2", {valid_m, reg_write_m}, 2'b00);
        drive(1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("load_in_m", {valid_m, reg_write_m, result_src_m}, 4'b1101);
        idle(3);

        // stall and flush together: flush wins
        drive(1'b1, 7'b0100011, 3'b010, 1'b1, 1'b1, 1'b1);
        chk("sf_valid_e", valid_e, 1'b0);
        chk("sf_mw_e", mem_write_e, 1'b0);

        // branch conditions on both BRANCH_EXT settings
        drive(1'b1, 7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0);
        chk("bne_br_e", {branch_e, branch_type_e}, 4'b1001);
        chk("bne_alu_e", alu_control_e, ALU_SUB);
        chk("bne_ill_b", illegal_d_b, 1'b1);
        chk("bne_bub_b", {valid_e_b, branch_e_b}, 2'b00);
        drive(1'b1, 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("beq_br_b", {valid_e_b, branch_e_b, illegal_d_b}, 3'b110);
        drive(1'b1, 7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b1100011, 3'b010, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b1100111, 3'b001, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0);
        // illegal words that are not accepted must not count
        drive(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 7'b1111111, 3'b000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
            en_acc = en_acc | reg_write_e | mem_write_e | branch_e | jump_e | jalr_e |
                     reg_write_m | mem_write_m | reg_write_w;
        end
        chk("sat_cnt", illegal_cnt, 8'd255);
        chk("sat_seen", illegal_seen, 1'b1);
        chk("sat_no_en", en_acc, 1'b0);

        // asynchronous reset with live words in the pipe
        drive(1'b1, 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("mrst_e", e_vec, 15'b0);
        chk("mrst_m", m_vec, 5'b0);
        chk("mrst_w", {valid_w, reg_write_w, result_src_w}, 4'b0);
        chk("mrst_cnt", {illegal_seen, illegal_cnt}, 9'b0);
        op_d = 7'b0110111;
        #1;
        chk("mrst_comb", imm_src_d, 3'b100);
        sb_q.delete();
        exp_e = '0; exp_m = '0; exp_cnt = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
